// File: rtl/lutram_fifo_pkg.sv
// Shared constants for RAM256X1D-based FIFOs and the pointer-to-address helper.
package lutram_fifo_pkg;

  localparam int unsigned LUTRAM_DEPTH = 256;
  localparam int unsigned LUTRAM_AW    = 8;

  // Pointers narrower than the RAM address keep their upper address bits at zero.
  function automatic logic [LUTRAM_AW-1:0] zext_ptr(input logic [LUTRAM_AW-1:0] ptr,
                                                    input int unsigned         aw);
    logic [LUTRAM_AW-1:0] mask;
    mask = LUTRAM_AW'((LUTRAM_DEPTH >> (LUTRAM_AW - aw)) - 1);
    return ptr & mask;
  endfunction

endpackage

// File: rtl/lutram_fifo_ctrl.sv
// Controller for a FIFO of DW RAM256X1D columns: drives the write port and read address,
// and registers the asynchronous DPO data into a first-word-fall-through output stage.
module lutram_fifo_ctrl
  import lutram_fifo_pkg::*;
#(
  parameter int unsigned DW        = 8,
  parameter int unsigned AW        = 8,
  parameter int unsigned AFULL_LVL = 240
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 FLUSH,
  input  logic                 S_VALID,
  output logic                 S_READY,
  input  logic [DW-1:0]        S_DATA,
  output logic                 M_VALID,
  input  logic                 M_READY,
  output logic [DW-1:0]        M_DATA,
  output logic [AW:0]          LEVEL,
  output logic                 ALMOST_FULL,
  output logic                 RAM_WE,
  output logic [LUTRAM_AW-1:0] RAM_A,
  output logic [DW-1:0]        RAM_D,
  output logic [LUTRAM_AW-1:0] RAM_DPRA,
  input  logic [DW-1:0]        RAM_DPO
);

  localparam logic [AW:0] FullCnt  = (AW+1)'(2**AW);
  localparam logic [AW:0] AfullCnt = (AW+1)'(AFULL_LVL);

  logic          rst_q;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic          m_valid_q, m_valid_d;
  logic [DW-1:0] m_data_q, m_data_d;
  logic          afull_q, afull_d;
  logic          s_ready;
  logic          push;
  logic          load;

  always_comb begin
    // rst_q holds S_READY low for the first cycle after reset release
    s_ready   = !rst_q && (cnt_q != FullCnt);
    push      = S_VALID && s_ready && !FLUSH;
    load      = (cnt_q != '0) && (!m_valid_q || M_READY) && !FLUSH;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    cnt_d     = cnt_q;
    m_valid_d = m_valid_q;
    m_data_d  = m_data_q;
    afull_d   = afull_q;
    if (FLUSH) begin
      wr_ptr_d  = '0;
      rd_ptr_d  = '0;
      cnt_d     = '0;
      m_valid_d = 1'b0;
      m_data_d  = '0;
      afull_d   = 1'b0;
    end else begin
      if (push) begin
        wr_ptr_d = wr_ptr_q + AW'(1);
      end
      if (load) begin
        rd_ptr_d  = rd_ptr_q + AW'(1);
        m_valid_d = 1'b1;
        m_data_d  = RAM_DPO;
      end else if (m_valid_q && M_READY) begin
        m_valid_d = 1'b0;
      end
      unique case ({push, load})
        2'b10:   cnt_d = cnt_q + (AW+1)'(1);
        2'b01:   cnt_d = cnt_q - (AW+1)'(1);
        default: cnt_d = cnt_q;
      endcase
      afull_d = (cnt_d >= AfullCnt);
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      rst_q     <= 1'b1;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      cnt_q     <= '0;
      m_valid_q <= 1'b0;
      m_data_q  <= '0;
      afull_q   <= 1'b0;
    end else begin
      rst_q     <= 1'b0;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      cnt_q     <= cnt_d;
      m_valid_q <= m_valid_d;
      m_data_q  <= m_data_d;
      afull_q   <= afull_d;
    end
  end

  assign S_READY     = s_ready;
  assign M_VALID     = m_valid_q;
  assign M_DATA      = m_data_q;
  assign LEVEL       = cnt_q + (AW+1)'(m_valid_q);
  assign ALMOST_FULL = afull_q;
  assign RAM_WE      = push;
  assign RAM_A       = zext_ptr(LUTRAM_AW'(wr_ptr_q), AW);
  assign RAM_D       = S_DATA;
  assign RAM_DPRA    = zext_ptr(LUTRAM_AW'(rd_ptr_q), AW);

endmodule

// File: tb/tb_lutram_fifo_ctrl.sv
// Directed bench for lutram_fifo_ctrl with a behavioural 256x1 distributed RAM per data bit.
module tb_lutram_fifo_ctrl;

  localparam int unsigned DW = 8;
  localparam int unsigned AW = 8;

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic          FLUSH = 1'b0;
  logic          S_VALID = 1'b0;
  logic          S_READY;
  logic [DW-1:0] S_DATA = '0;
  logic          M_VALID;
  logic          M_READY = 1'b0;
  logic [DW-1:0] M_DATA;
  logic [AW:0]   LEVEL;
  logic          ALMOST_FULL;
  logic          RAM_WE;
  logic [7:0]    RAM_A;
  logic [DW-1:0] RAM_D;
  logic [7:0]    RAM_DPRA;
  logic [DW-1:0] RAM_DPO;

  int checks = 0;
  int errors = 0;
  int pushes = 0;
  int pops   = 0;
  logic [DW-1:0] q[$];

  always #5 CLK = ~CLK;

  // One RAM256X1D per data bit: synchronous write, asynchronous read on DPRA.
  for (genvar c = 0; c < DW; c++) begin : g_col
    logic mem [256];
    always_ff @(posedge CLK) if (RAM_WE) mem[RAM_A] <= RAM_D[c];
    assign RAM_DPO[c] = mem[RAM_DPRA];
  end

  lutram_fifo_ctrl #(.DW(DW), .AW(AW), .AFULL_LVL(240)) dut (
    .CLK(CLK), .RST(RST), .FLUSH(FLUSH),
    .S_VALID(S_VALID), .S_READY(S_READY), .S_DATA(S_DATA),
    .M_VALID(M_VALID), .M_READY(M_READY), .M_DATA(M_DATA),
    .LEVEL(LEVEL), .ALMOST_FULL(ALMOST_FULL),
    .RAM_WE(RAM_WE), .RAM_A(RAM_A), .RAM_D(RAM_D),
    .RAM_DPRA(RAM_DPRA), .RAM_DPO(RAM_DPO)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: score the handshakes that complete at the coming edge.
  task automatic step();
    logic          do_push, do_pop;
    logic [DW-1:0] d;
    check("level", 32'(LEVEL), 32'(q.size()));
    do_push = S_VALID && S_READY && !FLUSH;
    do_pop  = M_VALID && M_READY;
    d       = S_DATA;
    if (do_pop) begin
      pops++;
      check("pop_has_data", 32'(q.size() != 0), 1);
      if (q.size() != 0) check("order", 32'(M_DATA), 32'(q.pop_front()));
    end
    @(posedge CLK);
    if (do_push) begin
      q.push_back(d);
      pushes++;
    end
    #1;
  endtask

  task automatic drain();
    int budget;
    budget  = 0;
    S_VALID = 1'b0;
    M_READY = 1'b1;
    while (LEVEL != 0 && budget < 600) begin
      step();
      budget++;
    end
    check("drain_empty", 32'(LEVEL), 0);
    check("drain_queue", 32'(q.size()), 0);
    M_READY = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int budget;
    S_VALID = 1'b1;
    S_DATA  = 8'h11;
    repeat (2) @(posedge CLK);
    #1;
    check("rst_m_valid", 32'(M_VALID), 0);
    check("rst_level", 32'(LEVEL), 0);
    check("rst_ram_we", 32'(RAM_WE), 0);
    check("rst_s_ready", 32'(S_READY), 0);
    RST     = 1'b0;
    S_VALID = 1'b0;
    check("rel_s_ready_low", 32'(S_READY), 0);
    @(posedge CLK);
    #1;
    check("rel_s_ready_high", 32'(S_READY), 1);

    // Single word with consumer stalled
    S_VALID = 1'b1;
    S_DATA  = 8'hA5;
    #1;
    check("single_ram_we", 32'(RAM_WE), 1);
    check("single_ram_a", 32'(RAM_A), 0);
    check("single_ram_d", 32'(RAM_D), 32'hA5);
    step();
    S_VALID = 1'b0;
    check("single_e0_m_valid", 32'(M_VALID), 0);
    check("single_e0_level", 32'(LEVEL), 1);
    step();
    check("single_e1_m_valid", 32'(M_VALID), 1);
    check("single_e1_m_data", 32'(M_DATA), 32'hA5);
    check("single_e1_level", 32'(LEVEL), 1);
    step();
    check("single_hold_valid", 32'(M_VALID), 1);
    check("single_hold_data", 32'(M_DATA), 32'hA5);
    M_READY = 1'b1;
    step();
    M_READY = 1'b0;
    check("single_pop_valid", 32'(M_VALID), 0);
    check("single_pop_level", 32'(LEVEL), 0);

    // Fill to 256 in RAM plus one in the output register
    for (int i = 0; i < 257; i++) begin
      S_VALID = 1'b1;
      S_DATA  = 8'(i);
      step();
      if (i == 239) check("afull_239", 32'(ALMOST_FULL), 0);
      if (i == 240) check("afull_240", 32'(ALMOST_FULL), 1);
    end
    check("fill_pushes", 32'(pushes), 258);
    check("fill_level", 32'(LEVEL), 257);
    check("fill_s_ready", 32'(S_READY), 0);
    check("fill_afull", 32'(ALMOST_FULL), 1);
    check("fill_m_data", 32'(M_DATA), 0);
    S_DATA = 8'h77;
    #1;
    check("full_ram_we", 32'(RAM_WE), 0);
    M_READY = 1'b1;
    step();
    S_VALID = 1'b0;
    check("full_pop_s_ready", 32'(S_READY), 1);
    check("full_pop_level", 32'(LEVEL), 256);
    drain();
    check("drain_afull", 32'(ALMOST_FULL), 0);

    // Random stream of 1000 words, wrapping the pointers several times
    pushes = 0;
    budget = 0;
    while (pushes < 1000 && budget < 8000) begin
      S_VALID = 1'($urandom_range(0, 1));
      S_DATA  = 8'(pushes * 7 + 3);
      M_READY = 1'($urandom_range(0, 1));
      step();
      budget++;
    end
    check("stream_pushed", 32'(pushes), 1000);
    drain();

    // Throughput: one word per cycle after a two-cycle fill
    pops    = 0;
    S_VALID = 1'b1;
    M_READY = 1'b1;
    for (int i = 0; i < 300; i++) begin
      S_DATA = 8'(i);
      step();
    end
    check("tput_pops", 32'(pops), 298);
    check("tput_level", 32'(LEVEL), 2);
    drain();

    // Flush with ten words queued and a push offered in the flush cycle
    for (int i = 0; i < 10; i++) begin
      S_VALID = 1'b1;
      S_DATA  = 8'(8'h10 + i);
      step();
    end
    S_VALID = 1'b0;
    step();
    check("pre_flush_level", 32'(LEVEL), 10);
    S_VALID = 1'b1;
    S_DATA  = 8'hEE;
    FLUSH   = 1'b1;
    #1;
    check("flush_ram_we", 32'(RAM_WE), 0);
    @(posedge CLK);
    #1;
    q.delete();
    FLUSH   = 1'b0;
    S_VALID = 1'b0;
    check("flush_level", 32'(LEVEL), 0);
    check("flush_m_valid", 32'(M_VALID), 0);
    check("flush_afull", 32'(ALMOST_FULL), 0);
    check("flush_m_data", 32'(M_DATA), 0);
    check("flush_ram_a", 32'(RAM_A), 0);
    check("flush_dpra", 32'(RAM_DPRA), 0);
    step();
    check("flush_dropped_valid", 32'(M_VALID), 0);
    check("flush_dropped_level", 32'(LEVEL), 0);

    // Reset asserted in the middle of a stream
    S_VALID = 1'b1;
    M_READY = 1'b1;
    for (int i = 0; i < 5; i++) begin
      S_DATA = 8'(8'h50 + i);
      step();
    end
    RST = 1'b1;
    #1;
    q.delete();
    check("midrst_m_valid", 32'(M_VALID), 0);
    check("midrst_level", 32'(LEVEL), 0);
    check("midrst_ram_we", 32'(RAM_WE), 0);
    check("midrst_s_ready", 32'(S_READY), 0);
    @(posedge CLK);
    #1;
    RST     = 1'b0;
    S_VALID = 1'b0;
    M_READY = 1'b0;
    check("midrst_rel_low", 32'(S_READY), 0);
    step();
    check("midrst_rel_high", 32'(S_READY), 1);
    S_VALID = 1'b1;
    S_DATA  = 8'h3C;
    step();
    S_VALID = 1'b0;
    step();
    check("post_rst_valid", 32'(M_VALID), 1);
    check("post_rst_data", 32'(M_DATA), 32'h3C);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
